// File: rtl/shift_reg_universal.sv
// shift_reg_universal: parametrised universal shift register with a valid/ready command port.
// Supports parallel load, multi-position logical/arithmetic shifts and rotates.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear; aborts any operation in flight, no done pulse
//   cmd_valid  command request; accepted when cmd_ready is high
//   cmd_ready  high while idle
//   cmd_op     000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 NOP
//   cmd_amt    shift/rotate positions, saturated to WIDTH
//   data_in    parallel load data
//   sin        serial fill bit, sampled on every shift edge
//   data_out   register contents
//   shift_out  last bit shifted or rotated out
//   busy       multi-cycle operation in progress
//   done       one-cycle completion pulse
module shift_reg_universal #(
    parameter int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sin,
    output logic [WIDTH-1:0] data_out,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [AMT_W-1:0] r_rem, w_rem_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt, w_step;
    logic             r_so, w_so_nxt, w_step_so;
    logic             r_done, w_done_nxt;
    logic [AMT_W-1:0] w_amt;
    logic             w_is_shift;

    assign busy      = (r_state == S_SHIFT);
    assign cmd_ready = !busy;
    assign data_out  = r_data;
    assign shift_out = r_so;
    assign done      = r_done;

    assign w_amt      = (cmd_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : cmd_amt;
    assign w_is_shift = (cmd_op >= OP_SHL) && (cmd_op != 3'b111);

    // One position of the latched operation
    always_comb begin
        w_step    = r_data;
        w_step_so = r_so;
        case (r_op)
            OP_SHL: begin w_step = {r_data[WIDTH-2:0], sin};              w_step_so = r_data[WIDTH-1]; end
            OP_SHR: begin w_step = {sin, r_data[WIDTH-1:1]};              w_step_so = r_data[0];       end
            OP_ROL: begin w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};  w_step_so = r_data[WIDTH-1]; end
            OP_ROR: begin w_step = {r_data[0], r_data[WIDTH-1:1]};        w_step_so = r_data[0];       end
            OP_ASR: begin w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};  w_step_so = r_data[0];       end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_rem_nxt   = r_rem;
        w_data_nxt  = r_data;
        w_so_nxt    = r_so;
        w_done_nxt  = 1'b0;
        if (r_state == S_SHIFT) begin
            w_data_nxt = w_step;
            w_so_nxt   = w_step_so;
            w_rem_nxt  = r_rem - AMT_W'(1);
            if (r_rem == AMT_W'(1)) begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end else if (cmd_valid) begin
            if (w_is_shift && w_amt != '0) begin
                w_state_nxt = S_SHIFT;
                w_op_nxt    = cmd_op;
                w_rem_nxt   = w_amt;
            end else begin
                // LOAD, NOP, reserved and zero-length shifts all finish immediately
                if (cmd_op == OP_LOAD) w_data_nxt = data_in;
                w_done_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_so    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_data  <= w_data_nxt;
            r_so    <= w_so_nxt;
            r_done  <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_shift_reg_universal.sv
// tb_shift_reg_universal: directed, table-driven checks of shift_reg_universal at WIDTH=8.
module tb_shift_reg_universal;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_amt = '0;
    logic [7:0] data_in = '0;
    logic       sin = 1'b0;
    logic [7:0] data_out;
    logic       shift_out;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    shift_reg_universal #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_amt(cmd_amt),
        .data_in(data_in), .sin(sin),
        .data_out(data_out), .shift_out(shift_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] amt;
        logic [7:0] din;
        logic       sin;
        logic [7:0] exp_d;
        logic       exp_so;
        int         exp_lat;
    } vec_t;

    vec_t vt[15];

    task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] din);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        data_in   = din;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int   cyc;
        int   k;
        logic bad;
        vt[0]  = '{3'b001, 4'd0,  8'hA5, 1'b0, 8'hA5, 1'b1, 0};
        vt[1]  = '{3'b010, 4'd1,  8'h00, 1'b1, 8'h4B, 1'b1, 1};
        vt[2]  = '{3'b001, 4'd0,  8'h81, 1'b0, 8'h81, 1'b1, 0};
        vt[3]  = '{3'b101, 4'd8,  8'h00, 1'b0, 8'h81, 1'b1, 8};
        vt[4]  = '{3'b101, 4'd12, 8'h00, 1'b0, 8'h81, 1'b1, 8};
        vt[5]  = '{3'b001, 4'd0,  8'h90, 1'b0, 8'h90, 1'b1, 0};
        vt[6]  = '{3'b110, 4'd2,  8'h00, 1'b1, 8'hE4, 1'b0, 2};
        vt[7]  = '{3'b000, 4'd5,  8'h11, 1'b1, 8'hE4, 1'b0, 0};
        vt[8]  = '{3'b011, 4'd0,  8'h22, 1'b1, 8'hE4, 1'b0, 0};
        vt[9]  = '{3'b111, 4'd3,  8'h33, 1'b1, 8'hE4, 1'b0, 0};
        vt[10] = '{3'b011, 4'd3,  8'h00, 1'b1, 8'hFC, 1'b1, 3};
        vt[11] = '{3'b100, 4'd2,  8'h00, 1'b0, 8'hF3, 1'b1, 2};
        vt[12] = '{3'b010, 4'd15, 8'h00, 1'b0, 8'h00, 1'b1, 8};
        vt[13] = '{3'b001, 4'd0,  8'h3C, 1'b0, 8'h3C, 1'b1, 0};
        vt[14] = '{3'b110, 4'd9,  8'h00, 1'b1, 8'h00, 1'b0, 8};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_data", data_out, 8'h00);
        chk("rst_so", shift_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);

        // LOAD A5 then SHL 3 with a serial stream 1,0,1
        issue(3'b001, 4'd0, 8'hA5);
        chk("load_data", data_out, 8'hA5);
        chk("load_done", done, 1'b1);
        chk("load_busy", busy, 1'b0);
        @(negedge clk);
        chk("load_done_pulse", done, 1'b0);
        sin = 1'b1;
        issue(3'b010, 4'd3, 8'h00);
        chk("shl_busy0", {busy, cmd_ready, done}, 3'b100);
        chk("shl_hold0", data_out, 8'hA5);
        @(negedge clk);
        chk("shl_d1", {data_out, shift_out, busy, cmd_ready}, {8'h4B, 1'b1, 1'b1, 1'b0});
        sin = 1'b0;
        @(negedge clk);
        chk("shl_d2", {data_out, shift_out, busy, cmd_ready}, {8'h96, 1'b0, 1'b1, 1'b0});
        sin = 1'b1;
        @(negedge clk);
        chk("shl_d3", {data_out, shift_out, busy, done}, {8'h2D, 1'b1, 1'b0, 1'b1});
        @(negedge clk);
        chk("shl_done_pulse", done, 1'b0);

        // Table of single commands, each run to completion
        for (int i = 0; i < 15; i++) begin
            sin = vt[i].sin;
            issue(vt[i].op, vt[i].amt, vt[i].din);
            cyc = 0;
            bad = 1'b0;
            for (k = 0; k < 40 && !done; k++) begin
                if (busy) cyc++;
                if (cmd_ready !== !busy) bad = 1'b1;
                @(negedge clk);
            end
            chk($sformatf("v%0d_done_seen", i), done, 1'b1);
            chk($sformatf("v%0d_busy_at_done", i), busy, 1'b0);
            chk($sformatf("v%0d_data", i), data_out, vt[i].exp_d);
            chk($sformatf("v%0d_so", i), shift_out, vt[i].exp_so);
            chk($sformatf("v%0d_lat", i), cyc, vt[i].exp_lat);
            chk($sformatf("v%0d_ready", i), bad, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
        end

        // Clear aborts a SHR 6 on the third shift edge; LOAD during busy is ignored
        sin = 1'b0;
        issue(3'b001, 4'd0, 8'hFF);
        issue(3'b011, 4'd6, 8'h00);
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        data_in   = 8'h55;
        @(negedge clk);
        chk("clr_e1", {data_out, busy, cmd_ready, done}, {8'h7F, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        chk("clr_e2", {data_out, busy, done}, {8'h3F, 1'b1, 1'b0});
        clr = 1'b1;
        @(negedge clk);
        chk("clr_e3", {data_out, shift_out, busy, done, cmd_ready}, {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        clr = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("clr_load", {data_out, done, busy}, {8'h55, 1'b1, 1'b0});

        // Asynchronous reset between edges during a rotate
        issue(3'b001, 4'd0, 8'hF0);
        issue(3'b100, 4'd5, 8'h00);
        @(negedge clk);
        chk("arst_pre", {data_out, busy}, {8'hE1, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_now", {data_out, shift_out, busy, done}, {8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_after", {data_out, busy, done, cmd_ready}, {8'h00, 1'b0, 1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
